nes_fetch_unit: RTL and testbench

//  Parametrised byte-serial instruction fetch for the NES 6502 core.
//  - Reads opcode plus 0..MAX_INSTR_SIZE-1 operand bytes over a req/gnt/rvalid memory port.
//  - Assembles the variable-length instruction and hands it to decode over valid/ready.
//  - Supports PC redirect (jump/branch/interrupt), with squash of an in-flight read.

---
 rtl/nes_cpu_pkg.sv | 36 +++
 rtl/nes_opcode_len_dec.sv | 12 +
 rtl/nes_fetch_unit.sv | 145 ++++++++++++++
 tb/tb_nes_fetch_unit.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nes_cpu_pkg.sv
// NES 6502 core shared types, constants and the opcode length table.
// Imported by the fetch unit and its opcode length decoder.
package nes_cpu_pkg;

    localparam int BYTE = 8;
    localparam int MAX_INSTR_SIZE = 3;
    localparam logic [BYTE-1:0] NOP = 8'hEA;

    typedef enum logic [1:0] {
        FETCH_OPCODE,
        FETCH_OPERAND,
        FETCH_INSTR_READY
    } fetch_state_t;

    // Unofficial opcodes fall through to length 1.
    function automatic logic [1:0] instr_length(input logic [BYTE-1:0] opcode);
        logic [1:0] len;
        len = 2'd1;
        case (opcode) inside
            8'b????_1101, 8'b???1_1001,
            8'b0???_1110, 8'h8E, 8'b101?_1110, 8'b11??_1110,
            8'h20, 8'h2C, 8'h4C, 8'h6C, 8'h8C,
            8'hAC, 8'hBC, 8'hCC, 8'hEC:
                len = 2'd3;
            8'b????_0001, 8'b????_0101, 8'b????_0110, 8'b???1_0000,
            8'h09, 8'h29, 8'h49, 8'h69, 8'hA9, 8'hC9, 8'hE9,
            8'hA0, 8'hA2, 8'hC0, 8'hE0,
            8'h24, 8'h84, 8'h94, 8'hA4, 8'hB4, 8'hC4, 8'hE4:
                len = 2'd2;
            default:
                len = 2'd1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/nes_opcode_len_dec.sv
// Combinational opcode length decoder for the 6502 fetch unit.
// Maps an opcode byte to its instruction length of 1..3 bytes.
module nes_opcode_len_dec
    import nes_cpu_pkg::*;
(
    input  logic [BYTE-1:0] opcode,
    output logic [1:0]      len
);

    assign len = instr_length(opcode);

endmodule

// File: rtl/nes_fetch_unit.sv
// Byte-serial 6502 instruction fetch: assembles variable-length
// instructions from a req/gnt/rvalid port and hands them to decode.
module nes_fetch_unit
    import nes_cpu_pkg::BYTE, nes_cpu_pkg::NOP, nes_cpu_pkg::fetch_state_t,
           nes_cpu_pkg::FETCH_OPCODE, nes_cpu_pkg::FETCH_OPERAND,
           nes_cpu_pkg::FETCH_INSTR_READY;
#(
    parameter int                       MEM_ADDR_SIZE  = 16,
    parameter logic [MEM_ADDR_SIZE-1:0] BOOT_ADDR      = '0,
    parameter int                       MAX_INSTR_SIZE = nes_cpu_pkg::MAX_INSTR_SIZE
) (
    input  logic                           clk_i,
    input  logic                           rst_ni,
    output logic                           mem_req_o,
    output logic [MEM_ADDR_SIZE-1:0]       mem_addr_o,
    input  logic                           mem_gnt_i,
    input  logic                           mem_rvalid_i,
    input  logic [BYTE-1:0]                mem_rdata_i,
    input  logic                           redirect_i,
    input  logic [MEM_ADDR_SIZE-1:0]       redirect_pc_i,
    output logic                           instr_valid_o,
    input  logic                           instr_ready_i,
    output logic [MAX_INSTR_SIZE*BYTE-1:0] instr_o,
    output logic [1:0]                     instr_len_o,
    output logic [MEM_ADDR_SIZE-1:0]       instr_pc_o
);

    localparam int IW = MAX_INSTR_SIZE * BYTE;
    localparam logic [IW-1:0] RST_INSTR = IW'(NOP);

    if (MAX_INSTR_SIZE < 3) begin : g_size_chk
        $error("MAX_INSTR_SIZE must be at least 3");
    end

    fetch_state_t             state_q, state_d;
    logic [MEM_ADDR_SIZE-1:0] pc_q, pc_d;
    logic [MEM_ADDR_SIZE-1:0] op_pc_q, op_pc_d;
    logic [MEM_ADDR_SIZE-1:0] ipc_q, ipc_d;
    logic [IW-1:0]            ibuf_q, ibuf_d;
    logic [1:0]               len_q, len_d;
    logic [1:0]               cnt_q, cnt_d;
    logic [1:0]               dec_len;
    logic                     outst_q, outst_d;
    logic                     discard_q, discard_d;
    logic                     active_q;
    logic                     accept;

    nes_opcode_len_dec u_len_dec (
        .opcode (mem_rdata_i),
        .len    (dec_len)
    );

    // active_q keeps the request low until the first cycle after reset release
    assign mem_req_o = active_q && (state_q != FETCH_INSTR_READY)
                     && !outst_q && !discard_q;
    assign accept        = mem_req_o && mem_gnt_i;
    assign mem_addr_o    = pc_q;
    assign instr_valid_o = (state_q == FETCH_INSTR_READY);
    assign instr_o       = ibuf_q;
    assign instr_len_o   = len_q;
    assign instr_pc_o    = ipc_q;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        op_pc_d   = op_pc_q;
        ipc_d     = ipc_q;
        ibuf_d    = ibuf_q;
        len_d     = len_q;
        cnt_d     = cnt_q;
        outst_d   = outst_q;
        discard_d = discard_q;

        if (accept) begin
            pc_d    = pc_q + MEM_ADDR_SIZE'(1);
            outst_d = 1'b1;
            if (state_q == FETCH_OPCODE) op_pc_d = pc_q;
        end

        if (mem_rvalid_i && discard_q) begin
            discard_d = 1'b0;
        end else if (mem_rvalid_i && outst_q) begin
            outst_d = 1'b0;
            unique case (state_q)
                FETCH_OPCODE: begin
                    ibuf_d             = '0;
                    ibuf_d[BYTE-1:0]   = mem_rdata_i;
                    ipc_d              = op_pc_q;
                    len_d              = dec_len;
                    cnt_d              = 2'd1;
                    state_d = (dec_len == 2'd1) ? FETCH_INSTR_READY
                                                : FETCH_OPERAND;
                end
                FETCH_OPERAND: begin
                    ibuf_d[BYTE*cnt_q +: BYTE] = mem_rdata_i;
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_d == len_q) state_d = FETCH_INSTR_READY;
                end
                default: ;
            endcase
        end

        if (state_q == FETCH_INSTR_READY && instr_ready_i) begin
            state_d = FETCH_OPCODE;
        end

        // A read granted but not yet returned must have its data dropped
        if (redirect_i) begin
            state_d   = FETCH_OPCODE;
            pc_d      = redirect_pc_i;
            outst_d   = 1'b0;
            discard_d = accept || ((outst_q || discard_q) && !mem_rvalid_i);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= FETCH_OPCODE;
            pc_q      <= BOOT_ADDR;
            op_pc_q   <= BOOT_ADDR;
            ipc_q     <= BOOT_ADDR;
            ibuf_q    <= RST_INSTR;
            len_q     <= 2'd1;
            cnt_q     <= 2'd0;
            outst_q   <= 1'b0;
            discard_q <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            op_pc_q   <= op_pc_d;
            ipc_q     <= ipc_d;
            ibuf_q    <= ibuf_d;
            len_q     <= len_d;
            cnt_q     <= cnt_d;
            outst_q   <= outst_d;
            discard_q <= discard_d;
            active_q  <= 1'b1;
        end
    end

    rvalid_needs_read: assert property (@(posedge clk_i) disable iff (!rst_ni)
        mem_rvalid_i |-> (outst_q || discard_q));

endmodule

// File: tb/tb_nes_fetch_unit.sv
// Scoreboard bench for nes_fetch_unit with a latency-configurable
// byte memory responder.
module tb_nes_fetch_unit;
    import nes_cpu_pkg::*;

    typedef struct packed {
        logic [23:0] instr;
        logic [1:0]  len;
        logic [15:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_ni;
    logic        mem_req_o;
    logic [15:0] mem_addr_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [7:0]  mem_rdata_i;
    logic        redirect_i;
    logic [15:0] redirect_pc_i;
    logic        instr_valid_o;
    logic        instr_ready_i;
    logic [23:0] instr_o;
    logic [1:0]  instr_len_o;
    logic [15:0] instr_pc_o;

    int n_vec = 0;
    int n_err = 0;
    exp_t exp_q[$];

    logic [7:0]  mem [0:65535];
    logic [15:0] gnt_log[$];
    int          gnt_lat = 0;
    int          rv_lat = 1;
    int          rv_cnt = 0;

    always #5 clk = ~clk;

    nes_fetch_unit dut (
        .clk_i         (clk),
        .rst_ni        (rst_ni),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_gnt_i     (mem_gnt_i),
        .mem_rvalid_i  (mem_rvalid_i),
        .mem_rdata_i   (mem_rdata_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_len_o   (instr_len_o),
        .instr_pc_o    (instr_pc_o)
    );

    // Memory responder: acts 1 time unit after each rising edge.
    initial begin : responder
        int          gwait;
        int          pwait;
        logic        pend;
        logic [15:0] paddr;
        gwait = 0; pwait = 0; pend = 1'b0; paddr = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_gnt_i = 1'b0;
            mem_rvalid_i = 1'b0;
            if (!rst_ni) begin
                pend = 1'b0;
                gwait = 0;
            end else begin
                if (pend) begin
                    if (pwait == 0) begin
                        mem_rvalid_i = 1'b1;
                        mem_rdata_i = mem[paddr];
                        pend = 1'b0;
                        rv_cnt++;
                    end else begin
                        pwait--;
                    end
                end
                if (mem_req_o && !pend) begin
                    if (gwait >= gnt_lat) begin
                        mem_gnt_i = 1'b1;
                        gnt_log.push_back(mem_addr_o);
                        pend = 1'b1;
                        paddr = mem_addr_o;
                        pwait = rv_lat - 1;
                        gwait = 0;
                    end else begin
                        gwait++;
                    end
                end else begin
                    gwait = 0;
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_redirect(input logic [15:0] pc);
        redirect_pc_i = pc;
        redirect_i = 1'b1;
        @(negedge clk);
        redirect_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        instr_ready_i = 1'b0;
        redirect_i = 1'b0;
        redirect_pc_i = '0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (mem_req_o !== 1'b0) begin
            n_err++; $display("FAIL rst_req: got %b want 0", mem_req_o);
        end
        n_vec++;
        if (instr_valid_o !== 1'b0) begin
            n_err++; $display("FAIL rst_valid: got %b want 0", instr_valid_o);
        end
        n_vec++;
        if (instr_o !== 24'h0000EA || instr_len_o !== 2'd1) begin
            n_err++;
            $display("FAIL rst_instr: got %h/%0d want 0000ea/1", instr_o, instr_len_o);
        end
        n_vec++;
        if (instr_pc_o !== 16'h0000 || mem_addr_o !== 16'h0000) begin
            n_err++;
            $display("FAIL rst_pc: got pc %h addr %h want 0000", instr_pc_o, mem_addr_o);
        end
        rst_ni = 1'b1;
        @(negedge clk);
        n_vec++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 16'h0000) begin
            n_err++;
            $display("FAIL first_req: got req %b addr %h want 1/0000", mem_req_o, mem_addr_o);
        end
    endtask

    task automatic test_single();
        exp_t e;
        exp_q.push_back('{instr: 24'h0000EA, len: 2'd1, pc: 16'h0000});
        @(negedge clk);
        n_vec++;
        if (instr_valid_o !== 1'b0) begin
            n_err++; $display("FAIL lat_early: valid got %b want 0", instr_valid_o);
        end
        @(negedge clk);
        n_vec++;
        if (instr_valid_o !== 1'b1) begin
            n_err++; $display("FAIL lat_valid: valid got %b want 1", instr_valid_o);
        end
        e = exp_q.pop_front();
        n_vec++;
        if ({instr_o, instr_len_o, instr_pc_o} !== e) begin
            n_err++;
            $display("FAIL single_instr: got %h/%0d/%h want %h/%0d/%h",
                     instr_o, instr_len_o, instr_pc_o, e.instr, e.len, e.pc);
        end
        instr_ready_i = 1'b1;
        @(negedge clk);
        instr_ready_i = 1'b0;
        n_vec++;
        if (mem_req_o !== 1'b1 || mem_addr_o !== 16'h0001) begin
            n_err++;
            $display("FAIL single_next: got req %b addr %h want 1/0001", mem_req_o, mem_addr_o);
        end
    endtask

    task automatic test_stall();
        exp_t e;
        bit   ok;
        int   n;
        mem[16'h0010] = 8'hAD;
        mem[16'h0011] = 8'h34;
        mem[16'h0012] = 8'h12;
        gnt_lat = 2;
        rv_lat = 1;
        exp_q.push_back('{instr: 24'h1234AD, len: 2'd3, pc: 16'h0010});
        do_redirect(16'h0010);
        ok = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (instr_valid_o) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        n_vec++;
        if (!ok) begin
            n_err++; $display("FAIL stall_timeout: valid got 0 want 1");
        end
        e = exp_q.pop_front();
        n_vec++;
        if ({instr_o, instr_len_o, instr_pc_o} !== e) begin
            n_err++;
            $display("FAIL stall_instr: got %h/%0d/%h want %h/%0d/%h",
                     instr_o, instr_len_o, instr_pc_o, e.instr, e.len, e.pc);
        end
        n = gnt_log.size();
        n_vec++;
        if (n < 3 || gnt_log[n-3] !== 16'h0010 || gnt_log[n-2] !== 16'h0011
            || gnt_log[n-1] !== 16'h0012) begin
            n_err++;
            $display("FAIL stall_addrs: last grants %h %h %h want 0010 0011 0012",
                     gnt_log[n-3], gnt_log[n-2], gnt_log[n-1]);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_vec++;
            if (mem_req_o !== 1'b0 || instr_valid_o !== 1'b1 || instr_o !== e.instr) begin
                n_err++;
                $display("FAIL stall_hold: req %b valid %b instr %h want 0/1/%h",
                         mem_req_o, instr_valid_o, instr_o, e.instr);
            end
        end
    endtask

    task automatic test_redirect_discard();
        exp_t e;
        bit   ok;
        int   rv_before;
        mem[16'h0013] = 8'h4C;
        mem[16'h8000] = 8'hEA;
        gnt_lat = 0;
        rv_lat = 4;
        exp_q.push_back('{instr: 24'h0000EA, len: 2'd1, pc: 16'h8000});
        instr_ready_i = 1'b1;
        @(negedge clk);
        instr_ready_i = 1'b0;
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (gnt_log.size() > 0 && gnt_log[gnt_log.size()-1] == 16'h0013) begin
                ok = 1'b1; break;
            end
            @(negedge clk);
        end
        n_vec++;
        if (!ok) begin
            n_err++; $display("FAIL disc_gnt_timeout: no grant at 0013");
        end
        @(negedge clk);
        rv_before = rv_cnt;
        do_redirect(16'h8000);
        ok = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (mem_req_o) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        n_vec++;
        if (!ok || rv_cnt !== rv_before + 1) begin
            n_err++;
            $display("FAIL disc_order: req %b rvalids since redirect %0d want 1/1",
                     mem_req_o, rv_cnt - rv_before);
        end
        n_vec++;
        if (mem_addr_o !== 16'h8000) begin
            n_err++; $display("FAIL disc_addr: got %h want 8000", mem_addr_o);
        end
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (instr_valid_o) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        e = exp_q.pop_front();
        n_vec++;
        if (!ok || {instr_o, instr_len_o, instr_pc_o} !== e) begin
            n_err++;
            $display("FAIL disc_instr: valid %b got %h/%0d/%h want %h/%0d/%h", ok,
                     instr_o, instr_len_o, instr_pc_o, e.instr, e.len, e.pc);
        end
        instr_ready_i = 1'b1;
        @(negedge clk);
        instr_ready_i = 1'b0;
    endtask

    task automatic test_wrap();
        exp_t e;
        bit   ok;
        int   n;
        mem[16'hFFFF] = 8'h20;
        mem[16'h0000] = 8'h00;
        mem[16'h0001] = 8'hC0;
        gnt_lat = 1;
        rv_lat = 2;
        exp_q.push_back('{instr: 24'hC00020, len: 2'd3, pc: 16'hFFFF});
        do_redirect(16'hFFFF);
        ok = 1'b0;
        for (int k = 0; k < 80; k++) begin
            if (instr_valid_o) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        e = exp_q.pop_front();
        n_vec++;
        if (!ok || {instr_o, instr_len_o, instr_pc_o} !== e) begin
            n_err++;
            $display("FAIL wrap_instr: valid %b got %h/%0d/%h want %h/%0d/%h", ok,
                     instr_o, instr_len_o, instr_pc_o, e.instr, e.len, e.pc);
        end
        n = gnt_log.size();
        n_vec++;
        if (n < 3 || gnt_log[n-3] !== 16'hFFFF || gnt_log[n-2] !== 16'h0000
            || gnt_log[n-1] !== 16'h0001) begin
            n_err++;
            $display("FAIL wrap_addrs: last grants %h %h %h want ffff 0000 0001",
                     gnt_log[n-3], gnt_log[n-2], gnt_log[n-1]);
        end
        instr_ready_i = 1'b1;
        @(negedge clk);
        instr_ready_i = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   got;
        mem[16'h0300] = 8'hE8;
        mem[16'h0301] = 8'hA2;
        mem[16'h0302] = 8'h07;
        mem[16'h0303] = 8'h8D;
        mem[16'h0304] = 8'h00;
        mem[16'h0305] = 8'h02;
        mem[16'h0306] = 8'h0A;
        gnt_lat = 0;
        rv_lat = 1;
        exp_q.push_back('{instr: 24'h0000E8, len: 2'd1, pc: 16'h0300});
        exp_q.push_back('{instr: 24'h0007A2, len: 2'd2, pc: 16'h0301});
        exp_q.push_back('{instr: 24'h02008D, len: 2'd3, pc: 16'h0303});
        exp_q.push_back('{instr: 24'h00000A, len: 2'd1, pc: 16'h0306});
        do_redirect(16'h0300);
        instr_ready_i = 1'b1;
        got = 0;
        for (int k = 0; k < 200 && got < 4; k++) begin
            if (instr_valid_o && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got++;
                n_vec++;
                if ({instr_o, instr_len_o, instr_pc_o} !== e) begin
                    n_err++;
                    $display("FAIL b2b_instr%0d: got %h/%0d/%h want %h/%0d/%h", got,
                             instr_o, instr_len_o, instr_pc_o, e.instr, e.len, e.pc);
                end
            end
            @(negedge clk);
        end
        instr_ready_i = 1'b0;
        n_vec++;
        if (got != 4) begin
            n_err++; $display("FAIL b2b_count: got %0d want 4", got);
        end
    endtask

    task automatic test_handshake_redirect();
        exp_t e;
        bit   ok;
        mem[16'h0200] = 8'hA9;
        mem[16'h0201] = 8'h55;
        exp_q.push_back('{instr: 24'h0000EA, len: 2'd1, pc: 16'h0307});
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (instr_valid_o) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        e = exp_q.pop_front();
        n_vec++;
        if (!ok || {instr_o, instr_len_o, instr_pc_o} !== e) begin
            n_err++;
            $display("FAIL hsr_pre: valid %b got %h/%0d/%h want %h/%0d/%h", ok,
                     instr_o, instr_len_o, instr_pc_o, e.instr, e.len, e.pc);
        end
        exp_q.push_back('{instr: 24'h0055A9, len: 2'd2, pc: 16'h0200});
        instr_ready_i = 1'b1;
        redirect_pc_i = 16'h0200;
        redirect_i = 1'b1;
        @(negedge clk);
        instr_ready_i = 1'b0;
        redirect_i = 1'b0;
        n_vec++;
        if (instr_valid_o !== 1'b0 || mem_req_o !== 1'b1 || mem_addr_o !== 16'h0200) begin
            n_err++;
            $display("FAIL hsr_next: valid %b req %b addr %h want 0/1/0200",
                     instr_valid_o, mem_req_o, mem_addr_o);
        end
        ok = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (instr_valid_o) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        e = exp_q.pop_front();
        n_vec++;
        if (!ok || {instr_o, instr_len_o, instr_pc_o} !== e) begin
            n_err++;
            $display("FAIL hsr_instr: valid %b got %h/%0d/%h want %h/%0d/%h", ok,
                     instr_o, instr_len_o, instr_pc_o, e.instr, e.len, e.pc);
        end
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL hsr_leftover: %0d expected entries left want 0", exp_q.size());
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++) mem[a] = 8'hEA;
        test_reset();
        test_single();
        test_stall();
        test_redirect_discard();
        test_wrap();
        test_back_to_back();
        test_handshake_redirect();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
